// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state, latched operation and
// the width of the RAM latency counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IFETCH   = 2'd1,
    DACCESS  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_t;

  // Wide enough for RAM_LATENCY-1 over the full 1..15 latency range.
  localparam int CNT_W = $clog2(16);

  function automatic op_t decode_data_op(input logic ren, input logic wen);
    if (wen)      return OP_WRITE;
    else if (ren) return OP_READ;
    else          return OP_NONE;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the arbiter.
// slave = arbiter view, master = requesters plus RAM view.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) ();

  // Requests are levels: one is accepted on an edge where the arbiter is
  // idle and neither ready is high; the matching ready then pulses for one
  // cycle, and requesters must drop or re-present the request afterwards.
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_data;
  logic              d_ren;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ren;
  logic              ram_wen;
  logic [DATA_W-1:0] ram_rdata;
  logic [31:0]       stall_cnt;
  arb_state_t        dbg_state;

  modport slave (
    input  i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ram_rdata,
    output i_ready, i_data, d_ready, d_rdata,
           ram_addr, ram_wdata, ram_ren, ram_wen, stall_cnt, dbg_state
  );

  modport master (
    output i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ram_rdata,
    input  i_ready, i_data, d_ready, d_rdata,
           ram_addr, ram_wdata, ram_ren, ram_wen, stall_cnt, dbg_state
  );

endinterface

// File: rtl/mem_arbiter_wait_counter.sv
// Down-counter that times a RAM access: loaded on acceptance, decremented
// every busy edge, flags zero on the completing edge.
module wait_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             nRST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between an instruction fetch port and a data port,
// data side has priority. Define MEM_ARB_STATS_EN to enable the stall counter.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int RAM_LATENCY = 2
)
(
  input  logic           clk,
  input  logic           nRST,
  mem_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(RAM_LATENCY - 1);

  arb_state_t        state_q, state_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_data_q, i_data_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              cnt_zero;
  logic              busy;
  logic              accept;
  logic              done;
  logic              ram_ren_c, ram_wen_c;

  assign busy   = (state_q != IDLE);
  assign accept = (state_q == IDLE) && (state_d != IDLE);
  assign done   = busy && cnt_zero;

  wait_counter u_wait (
    .clk      (clk),
    .nRST     (nRST),
    .load     (accept),
    .load_val (LOAD_VAL),
    .dec      (busy),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // The ready flops double as the one-cycle turnaround block.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!i_ready_q && !d_ready_q) begin
          if (bus.d_ren || bus.d_wen) state_d = DACCESS;
          else if (bus.i_req)         state_d = IFETCH;
        end
      end
      IFETCH, DACCESS: begin
        if (cnt_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_ren_c = 1'b0;
    ram_wen_c = 1'b0;
    if (busy) begin
      ram_ren_c = (op_q == OP_READ);
      ram_wen_c = (op_q == OP_WRITE);
    end
  end

  always_comb begin
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    if (accept) begin
      wdata_d = bus.d_wdata;
      if (state_d == DACCESS) begin
        addr_d = bus.d_addr;
        op_d   = decode_data_op(bus.d_ren, bus.d_wen);
      end else begin
        addr_d = bus.i_addr;
        op_d   = OP_READ;
      end
    end
    if (done) begin
      op_d = OP_NONE;
      if (state_q == IFETCH) begin
        i_data_d  = bus.ram_rdata;
        i_ready_d = 1'b1;
      end else begin
        if (op_q == OP_READ) d_rdata_d = bus.ram_rdata;
        d_ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      op_q      <= OP_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((bus.i_req || bus.d_ren || bus.d_wen) && !i_ready_q && !d_ready_q &&
        (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif

  assign bus.i_ready   = i_ready_q;
  assign bus.i_data    = i_data_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ram_ren   = ram_ren_c;
  assign bus.ram_wen   = ram_wen_c;
  assign bus.dbg_state = state_q;

endmodule
